vcve2_dmem_responder: RTL and testbench

VCVE2_DMEM_RESPONDER -- requirements
Module: vcve2_dmem_responder

---
 rtl/vcve2_dmem_pkg.sv | 28 ++
 rtl/vcve2_dmem_resp_pipe.sv | 29 ++
 rtl/vcve2_dmem_responder.sv | 110 +++++++++++
 tb/tb_vcve2_dmem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vcve2_dmem_pkg.sv
// Shared types and constants for the vcve2 data-memory responder.
//   resp_t       : one response record (valid, err, rdata) carried by the delay line
//   *_MIN/*_MAX  : legal parameter ranges checked at elaboration
//   word_offset  : byte address -> word offset relative to a base (wraps below base)
package vcve2_dmem_pkg;

  localparam int unsigned LATENCY_MIN         = 1;
  localparam int unsigned LATENCY_MAX         = 4;
  localparam int unsigned MAX_OUTSTANDING_MIN = 1;
  localparam int unsigned MEM_WORDS_MIN       = 16;
  localparam int unsigned MEM_WORDS_MAX       = 65536;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  // Unsigned subtraction: an address below base wraps to a huge offset,
  // so it fails the range check like any other out-of-window address.
  function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    logic [31:0] diff;
    diff = addr - base;
    return {2'b00, diff[31:2]};
  endfunction

endpackage

// File: rtl/vcve2_dmem_resp_pipe.sv
// LATENCY-stage response delay line.
//   clk_i, rst_i : clock, asynchronous active-high reset (clears every stage)
//   resp_i       : response record launched in the accepting cycle
//   resp_o       : the same record, LATENCY cycles later
module vcve2_dmem_resp_pipe
  import vcve2_dmem_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  resp_t resp_i,
  output resp_t resp_o
);

  resp_t stage_q [LATENCY];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= resp_i;
      for (int unsigned i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/vcve2_dmem_responder.sv
// Data-memory responder: SRAM-backed target for an OBI-like req/gnt/rvalid bus.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   data_req_i        : request valid           data_gnt_o    : request accepted
//   data_we_i/be_i    : write enable, byte mask data_addr_i   : byte address
//   data_wdata_i      : write data              data_rvalid_o : response valid
//   data_rdata_o      : read data (0 unless rvalid)
//   data_err_o        : misaligned / out-of-window flag (0 unless rvalid)
//   stall_i           : forces data_gnt_o low
module vcve2_dmem_responder
  import vcve2_dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  input  logic        stall_i
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("vcve2_dmem_responder: LATENCY must be 1..4");
  end
  if (MAX_OUTSTANDING < MAX_OUTSTANDING_MIN || MAX_OUTSTANDING > LATENCY + 1) begin : g_bad_mo
    $error("vcve2_dmem_responder: MAX_OUTSTANDING must be 1..LATENCY+1");
  end
  if (MEM_WORDS < MEM_WORDS_MIN || MEM_WORDS > MEM_WORDS_MAX ||
      (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
    $error("vcve2_dmem_responder: MEM_WORDS must be a power of two in 16..65536");
  end
  if ((BASE_ADDR & (MEM_WORDS * 4 - 1)) != 0) begin : g_bad_base
    $error("vcve2_dmem_responder: BASE_ADDR must be aligned to MEM_WORDS*4");
  end

  logic [31:0]   mem_q [MEM_WORDS];
  logic [CW-1:0] outstanding_q, outstanding_d;
  resp_t         resp_d, resp_out;
  logic [31:0]   woff;
  logic [AW-1:0] widx;
  logic          req_err, accept;

  assign woff    = word_offset(data_addr_i, BASE_ADDR);
  assign widx    = woff[AW-1:0];
  assign req_err = (data_addr_i[1:0] != 2'b00) || (woff >= MEM_WORDS);

  // A response retiring this cycle frees a slot, so a full counter still grants.
  assign data_gnt_o = !rst_i && data_req_i && !stall_i &&
                      ((outstanding_q < CW'(MAX_OUTSTANDING)) || resp_out.valid);
  assign accept     = data_req_i && data_gnt_o;

  // Read data is captured in the accepting cycle, before that cycle's own write lands.
  always_comb begin
    resp_d = '0;
    if (accept) begin
      resp_d.valid = 1'b1;
      resp_d.err   = req_err;
      if (!req_err && !data_we_i) resp_d.rdata = mem_q[widx];
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, resp_out.valid})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) outstanding_q <= '0;
    else       outstanding_q <= outstanding_d;
  end

  // SRAM contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && data_we_i && !req_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem_q[widx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  vcve2_dmem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .resp_i (resp_d),
    .resp_o (resp_out)
  );

  assign data_rvalid_o = resp_out.valid;
  assign data_rdata_o  = resp_out.valid ? resp_out.rdata : '0;
  assign data_err_o    = resp_out.valid && resp_out.err;

endmodule

// File: tb/tb_vcve2_dmem_responder.sv
// Directed self-checking bench. Three responders share one stimulus bus:
//   u_l1 : LATENCY=1, MAX_OUTSTANDING=2, 64 words at 0x0
//   u_l3 : LATENCY=3, MAX_OUTSTANDING=2, 16 words at 0x1000
//   u_l2 : LATENCY=2, MAX_OUTSTANDING=2, 64 words at 0x0
// Each step checks only the instance under test; the others absorb the traffic.
module tb_vcve2_dmem_responder;

  logic        clk, rst, req, we, stall;
  logic [3:0]  be;
  logic [31:0] addr, wdata;

  logic        gnt1, rv1, er1, gnt3, rv3, er3, gnt2, rv2, er2;
  logic [31:0] rd1, rd3, rd2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic        vw   [7];
  logic [31:0] vaddr[7];
  logic [31:0] vwd  [7];
  logic        ver  [7];
  logic [31:0] vrd  [7];
  logic [5:0]  exp_g, exp_r;

  vcve2_dmem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(2)) u_l1 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt1), .data_rvalid_o(rv1),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rdata_o(rd1), .data_err_o(er1), .stall_i(stall));

  vcve2_dmem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h1000), .LATENCY(3), .MAX_OUTSTANDING(2)) u_l3 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt3), .data_rvalid_o(rv3),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rdata_o(rd3), .data_err_o(er3), .stall_i(stall));

  vcve2_dmem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .LATENCY(2), .MAX_OUTSTANDING(2)) u_l2 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt2), .data_rvalid_o(rv2),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rdata_o(rd2), .data_err_o(er2), .stall_i(stall));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; we = w; be = b; addr = a; wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vw    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vaddr = '{32'h0, 32'h12, 32'h100, 32'h12, 32'h100, 32'h0, 32'h10};
    vwd   = '{32'h11223344, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    ver   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vrd   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11223344, 32'hDEADAAEF};
    exp_g = 6'b011011;
    exp_r = 6'b011000;

    rst = 1'b1; stall = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    req = 1'b1;
    #1;
    chkb("rst_gnt", gnt1, 1'b0);
    chkb("rst_rvalid", rv1, 1'b0);
    chk("rst_rdata", rd1, 32'h0);
    chkb("rst_err", er1, 1'b0);
    chk("rst_outstanding", 32'(u_l1.outstanding_q), 32'h0);
    idle();
    rst = 1'b0;

    // Full write then read-back, LATENCY=1.
    next(); drive(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF); #1;
    chkb("wr_gnt", gnt1, 1'b1);
    chkb("wr_no_early_rvalid", rv1, 1'b0);
    next(); drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0); #1;
    chkb("wr_rvalid", rv1, 1'b1);
    chk("wr_rdata", rd1, 32'h0);
    chkb("wr_err", er1, 1'b0);
    chkb("rd_gnt", gnt1, 1'b1);
    next(); idle(); #1;
    chkb("rd_rvalid", rv1, 1'b1);
    chk("rd_rdata", rd1, 32'hDEADBEEF);
    chkb("rd_err", er1, 1'b0);
    next(); #1;
    chkb("rvalid_one_cycle", rv1, 1'b0);
    chk("rdata_idle_zero", rd1, 32'h0);
    repeat (3) next();

    // Partial byte write.
    next(); drive(1'b1, 1'b1, 4'b0010, 32'h10, 32'h0000AA00); #1;
    chkb("be_wr_gnt", gnt1, 1'b1);
    next(); drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0); #1;
    next(); idle(); #1;
    chkb("be_rd_rvalid", rv1, 1'b1);
    chk("be_rd_rdata", rd1, 32'hDEADAAEF);
    repeat (3) next();

    // Back-to-back mix of good and error accesses.
    for (int i = 0; i < 8; i++) begin
      next();
      if (i < 7) drive(1'b1, vw[i], 4'hF, vaddr[i], vwd[i]);
      else       idle();
      #1;
      if (i < 7) chkb("vec_gnt", gnt1, 1'b1);
      if (i > 0) begin
        chkb("vec_rvalid", rv1, 1'b1);
        chkb("vec_err", er1, ver[i-1]);
        chk("vec_rdata", rd1, vrd[i-1]);
      end
    end
    next(); #1;
    chkb("vec_drained", rv1, 1'b0);
    repeat (5) next();

    // LATENCY=3, MAX_OUTSTANDING=2 with request held for 6 cycles.
    for (int i = 0; i < 6; i++) begin
      next(); drive(1'b1, 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D); #1;
      chkb("l3_gnt", gnt3, exp_g[i]);
      chkb("l3_rvalid", rv3, exp_r[i]);
      chkb("l3_out_max", u_l3.outstanding_q <= 2'd2, 1'b1);
      if (exp_r[i]) begin
        chkb("l3_wr_err", er3, 1'b0);
        chk("l3_wr_rdata", rd3, 32'h0);
      end
    end
    next(); idle(); #1;
    chkb("l3_tail_rvalid6", rv3, 1'b1);
    next(); #1;
    chkb("l3_tail_rvalid7", rv3, 1'b1);
    next(); #1;
    chkb("l3_tail_idle", rv3, 1'b0);

    // Read back, and an address just below BASE_ADDR.
    next(); drive(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0); #1;
    chkb("l3_rd_gnt", gnt3, 1'b1);
    next(); drive(1'b1, 1'b0, 4'h0, 32'h0FFC, 32'h0); #1;
    chkb("l3_below_gnt", gnt3, 1'b1);
    next(); idle(); #1;
    chkb("l3_rd_not_yet", rv3, 1'b0);
    next(); #1;
    chkb("l3_rd_rvalid", rv3, 1'b1);
    chk("l3_rd_rdata", rd3, 32'hCAFEF00D);
    chkb("l3_rd_err", er3, 1'b0);
    next(); #1;
    chkb("l3_below_rvalid", rv3, 1'b1);
    chkb("l3_below_err", er3, 1'b1);
    chk("l3_below_rdata", rd3, 32'h0);
    repeat (3) next();

    // Stall for three cycles with one read in flight.
    next(); drive(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0); #1;
    chkb("stall_pre_gnt", gnt3, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      next(); stall = 1'b1; #1;
      chkb("stall_gnt", gnt3, 1'b0);
      chkb("stall_rvalid", rv3, (k == 3));
      if (k == 1) chkb("stall_gnt_idle_dut", gnt1, 1'b0);
      if (k == 3) chk("stall_rdata", rd3, 32'hCAFEF00D);
    end
    next(); stall = 1'b0; idle(); #1;
    chkb("stall_no_extra_rvalid", rv3, 1'b0);
    repeat (3) next();

    // Reset one cycle after two grants, LATENCY=2.
    next(); drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0); #1;
    chkb("l2_gnt0", gnt2, 1'b1);
    next(); drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0); #1;
    chkb("l2_gnt1", gnt2, 1'b1);
    next(); idle(); rst = 1'b1; #1;
    chkb("l2_rst_rvalid", rv2, 1'b0);
    chk("l2_rst_rdata", rd2, 32'h0);
    chk("l2_rst_outstanding", 32'(u_l2.outstanding_q), 32'h0);
    next(); rst = 1'b0; drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0); #1;
    chkb("l2_post_rst_gnt", gnt2, 1'b1);
    chkb("l2_post_rst_rvalid3", rv2, 1'b0);
    next(); idle(); #1;
    chkb("l2_post_rst_rvalid4", rv2, 1'b0);
    next(); #1;
    chkb("l2_new_rvalid", rv2, 1'b1);
    chk("l2_new_rdata", rd2, 32'hDEADAAEF);
    chkb("l2_new_err", er2, 1'b0);
    next(); #1;
    chkb("l2_new_done", rv2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
